// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the bit-serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic Cout,
  output logic s
);
  assign s    = a ^ b ^ Cin;
  assign Cout = (a & b) | (Cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: W-bit adder feeding one bit pair per clock, LSB first, through a single fulladder.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  sa_state_t state, state_next;
  logic [W-1:0] a_sh, b_sh, s_sh, s_next;
  logic [CW-1:0] cnt;
  logic carry, fa_cout, fa_s, last, load;
  fulladder u_fa (a_sh[0], b_sh[0], carry, fa_cout, fa_s);
  assign last   = cnt == CW'(W - 1);
  assign load   = start && state != SHIFT;
  // shift form keeps W = 1 legal without a special case
  assign s_next = (s_sh >> 1) | (W'(fa_s) << (W - 1));
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  always_comb begin
    state_next = state;
    state_next = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= s_next;
        cout <= fa_cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against {cout,sum} = a+b+cin.
module tb_serial_adder;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start = 0, cin = 0, busy, done, cout;
  logic [7:0] a = 0, b = 0, sum;
  logic start1 = 0, a1 = 0, b1 = 0, cin1 = 0, busy1, done1, sum1, cout1;
  int checks = 0, failures = 0;

  serial_adder #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a_in(a), .b_in(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout));
  serial_adder #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  // issue one W=8 addition and check latency, busy, hold-until-done and result
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input string name);
    logic [8:0] exp, prev;
    int lat;
    bit busy_ok, held_ok;
    exp = 9'(x) + 9'(y) + 9'(c);
    @(negedge clk);
    prev = {cout, sum};
    start = 1; a = x; b = y; cin = c;
    lat = 0; busy_ok = 1; held_ok = 1;
    for (int n = 1; n <= 14 && lat == 0; n++) begin
      @(negedge clk);
      start = 0;
      if (done) lat = n;
      else begin
        if (!busy) busy_ok = 0;
        if ({cout, sum} !== prev) held_ok = 0;
      end
    end
    checks++;
    if (lat != 9) begin failures++; $display("FAIL %s latency got=%0d exp=9", name, lat); end
    checks++;
    if (!busy_ok) begin failures++; $display("FAIL %s busy not high throughout shift", name); end
    checks++;
    if (!held_ok) begin failures++; $display("FAIL %s result changed before done", name); end
    checks++;
    if ({cout, sum} !== exp) begin
      failures++; $display("FAIL %s result got=%h exp=%h", name, {cout, sum}, exp);
    end
  endtask

  task automatic op1(input logic x, input logic y, input logic c, input string name);
    logic [1:0] exp;
    exp = 2'(x) + 2'(y) + 2'(c);
    @(negedge clk);
    start1 = 1; a1 = x; b1 = y; cin1 = c;
    @(negedge clk);
    start1 = 0;
    checks++;
    if (busy1 !== 1 || done1 !== 0) begin
      failures++; $display("FAIL %s w1 shift busy=%b done=%b exp busy=1 done=0", name, busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1 || {cout1, sum1} !== exp) begin
      failures++; $display("FAIL %s w1 done=%b result got=%b exp=%b", name, done1, {cout1, sum1}, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== 11'd0 || {busy1, done1, cout1, sum1} !== 4'd0) begin
      failures++; $display("FAIL reset outputs got=%h/%b exp=0", {busy, done, cout, sum}, {busy1, done1, cout1, sum1});
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    op8(8'h35, 8'h4A, 0, "basic");
    op8(8'hFF, 8'h01, 0, "carry_out");
    op8(8'hFF, 8'hFF, 1, "all_ones");
  endtask

  // start during shift ignored, then start held through done cycle
  task automatic test_ignore_and_back_to_back;
    int lat;
    bit held_ok;
    @(negedge clk);
    start = 1; a = 8'h10; b = 8'h20; cin = 0;
    lat = 0;
    for (int n = 1; n <= 14 && lat == 0; n++) begin
      @(negedge clk);
      start = 0;
      if (n == 3) begin start = 1; a = 8'hAA; b = 8'h55; end
      if (done) lat = n;
    end
    checks++;
    if (lat != 9 || {cout, sum} !== 9'h030) begin
      failures++; $display("FAIL ignore_start lat=%0d result got=%h exp=030", lat, {cout, sum});
    end
    start = 1; a = 8'h01; b = 8'h02; cin = 0;
    lat = 0; held_ok = 1;
    for (int n = 1; n <= 14 && lat == 0; n++) begin
      @(negedge clk);
      start = 0;
      if (done) lat = n;
      else if ({cout, sum} !== 9'h030) held_ok = 0;
    end
    checks++;
    if (!held_ok) begin failures++; $display("FAIL back_to_back first result not held, got=%h exp=030", {cout, sum}); end
    checks++;
    if (lat != 9 || {cout, sum} !== 9'h003) begin
      failures++; $display("FAIL back_to_back lat=%0d result got=%h exp=003", lat, {cout, sum});
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start = 1; a = 8'h77; b = 8'h11; cin = 1;
    repeat (4) begin @(negedge clk); start = 0; end
    checks++;
    if (busy !== 1) begin failures++; $display("FAIL async_reset precondition busy=%b exp=1", busy); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      failures++; $display("FAIL async_reset outputs got=%h exp=0", {busy, done, cout, sum});
    end
    @(negedge clk);
    rst_n = 1;
    op8(8'h0F, 8'h01, 0, "after_reset");
  endtask

  task automatic test_w1;
    op1(1, 1, 1, "w1_ones");
    for (int i = 0; i < 8; i++) op1(1'($urandom), 1'($urandom), 1'($urandom), "w1_random");
  endtask

  task automatic test_random;
    for (int i = 0; i < 256; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_and_back_to_back;
    test_async_reset;
    test_w1;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial W-bit adder built around the team's existing single-bit `fulladder` cell.
- Loads two operands and a carry-in on `start`, then feeds one bit pair per clock, LSB first, into `fulladder`.
- Registers the carry between cycles and shifts sum bits into a result register.
- Trades W cycles of latency for a single adder cell; acts as the sequencing stage that drives the full adder and consumes its outputs.

Parameters:
- W, 8, operand/sum width in bits; legal range W >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge of clk.
- a_in  input  W  operand A; captured only when start is accepted.
- b_in  input  W  operand B; captured only when start is accepted.
- cin  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while the addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid and newly updated.
- sum  output  W  result of the last completed addition; held until the next completion.
- cout  output  1  carry-out of the last completed addition; held like sum.

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0.
  - Shift registers, carry register and bit counter cleared.
  - Reset mid-operation aborts the addition and discards partial results.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1: load a_sh <= a_in, b_sh <= b_in, carry <= cin, cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle:
  - `fulladder` inputs are a_sh[0], b_sh[0], carry.
  - On each edge: carry <= Cout; s_sh <= {s, s_sh[W-1:1]}; a_sh and b_sh shift right by 1 with 0 fill; cnt <= cnt + 1.
  - When cnt == W-1 at the edge, the last bit is processed:
    - sum <= {s, s_sh[W-1:1]}, cout <= Cout.
    - Go to DONE.
- DONE:
  - done = 1 for exactly this cycle; busy = 0.
  - If start = 1: load new operands and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Output decode:
  - busy = (state == SHIFT).
  - done = (state == DONE).
  - Both are decoded from registered state, so they are glitch-free.
- Latency:
  - start accepted at edge k → done high during the cycle after edge k+W.
  - Throughput is one result per W+1 cycles; back-to-back issue gives the same rate.
- start while busy is ignored; operands are not re-sampled.
- sum and cout change only at the completion edge, never during SHIFT.
- Arithmetic is modulo 2^W with carry exposed on cout: {cout, sum} = a_in + b_in + cin.
- cnt width is $clog2(W) with a minimum of 1 bit; no wrap issue because cnt is reloaded on every start.
- W = 1: SHIFT lasts exactly one cycle.
- No combinational path from inputs to outputs.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
  - No other shared constants; W stays a module parameter.
- One sub-module: the existing `fulladder`.
  - Instantiate it with positional port order (a, b, Cin, Cout, s).
  - No new sub-modules.

Test Plan:
- W=8, a=0x35, b=0x4A, cin=0, pulse start → busy for 8 cycles, done 8 cycles after the start edge, sum=0x7F, cout=0.
- W=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start 0x10+0x20; at cycle 3 drive start=1 with a=0xAA, b=0x55 → ignored, result is sum=0x30, cout=0.
- Hold start=1 through the done cycle with new operands 0x01+0x02 → second operation begins immediately, next done W+1 cycles later with sum=0x03; first result 0x30 visible in between.
- Deassert rst_n asynchronously mid-SHIFT at cycle 4 → busy, done, sum, cout go to 0 immediately; after release, a fresh 0x0F+0x01 gives sum=0x10.
- Parameter W=1: 1+1, cin=1 → done one cycle after SHIFT, sum=1, cout=1. Also run a 256-pair random sweep at W=8 checked against {cout, sum} = a+b+cin.
